// File: rtl/ascon_rate_packer.sv
// rtl/ascon_rate_packer.sv - packs byte-counted message beats into ASCON rate blocks
// Ports:
//   clock_i, resetb_i        : clock, asynchronous active-low reset
//   rate_sel_i               : 0 = 8-byte rate, 1 = 16-byte rate (sampled on a message's first beat)
//   in_valid_i / in_ready_o  : input beat handshake
//   in_data_i, in_bytes_i    : MSB-aligned beat bytes and their count (clamped to NB_BITS_DATA/8)
//   in_last_i                : final beat of a message
//   out_valid_o / out_ready_i: output block handshake
//   out_data_o, out_bytes_o  : MSB-aligned rate block and its message-byte count
//   out_last_o               : final block of a message
// Build option: define ASCON_PAD_EN to append the 0x80 pad byte after the final residual.
module ascon_rate_packer #(
  parameter int NB_BITS_DATA = 64,
  parameter int BLOCK_W      = 128
) (
  input  logic                                clock_i,
  input  logic                                resetb_i,
  input  logic                                rate_sel_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [NB_BITS_DATA-1:0]             in_data_i,
  input  logic [$clog2(NB_BITS_DATA/8+1)-1:0] in_bytes_i,
  input  logic                                in_last_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [BLOCK_W-1:0]                  out_data_o,
  output logic [4:0]                          out_bytes_o,
  output logic                                out_last_o
);
  localparam int IN_BYTES = NB_BITS_DATA / 8;
  localparam int CNT_W    = $clog2(IN_BYTES + 1);
  // Room for a nearly full rate block plus one more beat.
  localparam int ACC_W    = BLOCK_W + NB_BITS_DATA;
  localparam int FILL_W   = 6;
  localparam int SH_W     = FILL_W + 3;

  typedef enum logic [1:0] {ST_ACCUM, ST_FULL, ST_FINAL} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              rate_q, rate_d;          // 1 = 16-byte rate
  logic              in_msg_q, in_msg_d;      // a message is in progress, rate is locked
  logic              last_seen_q, last_seen_d;

  logic [CNT_W-1:0]        nb;
  logic [SH_W-1:0]         nb_sh, fill_sh, rate_sh;
  logic [NB_BITS_DATA-1:0] beat_bytes;
  logic [ACC_W-1:0]        beat_placed;
  logic [FILL_W-1:0]       new_fill, rate_bytes, beat_rate_bytes;
  logic                    beat_noop, beat_rate, in_acc, out_acc;
  logic [BLOCK_W-1:0]      rate_mask, block_data;
`ifdef ASCON_PAD_EN
  logic [BLOCK_W-1:0]      pad_vec;
`endif

  // Datapath helpers shared by next-state and output logic.
  always_comb begin
    nb              = (in_bytes_i > CNT_W'(IN_BYTES)) ? CNT_W'(IN_BYTES) : in_bytes_i;
    nb_sh           = SH_W'({nb, 3'b000});
    fill_sh         = {fill_q, 3'b000};
    // Drop bytes below the valid count so stale data never reaches the block.
    beat_bytes      = in_data_i & ~({NB_BITS_DATA{1'b1}} >> nb_sh);
    beat_placed     = {beat_bytes, {BLOCK_W{1'b0}}} >> fill_sh;
    new_fill        = fill_q + FILL_W'(nb);
    beat_noop       = (nb == '0) && !in_last_i;
    // The first beat of a message uses the live select; later beats use the latched one.
    beat_rate       = in_msg_q ? rate_q : rate_sel_i;
    beat_rate_bytes = beat_rate ? FILL_W'(16) : FILL_W'(8);
    rate_bytes      = rate_q ? FILL_W'(16) : FILL_W'(8);
    rate_sh         = {rate_bytes, 3'b000};
    rate_mask       = rate_q ? {BLOCK_W{1'b1}} : {{(BLOCK_W/2){1'b1}}, {(BLOCK_W/2){1'b0}}};
    block_data      = acc_q[ACC_W-1 -: BLOCK_W] & rate_mask;
    in_acc          = in_valid_i && in_ready_o;
    out_acc         = out_valid_o && out_ready_i;
`ifdef ASCON_PAD_EN
    pad_vec         = {8'h80, {(BLOCK_W-8){1'b0}}} >> fill_sh;
`endif
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      fill_q      <= '0;
      rate_q      <= 1'b0;
      in_msg_q    <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      rate_q      <= rate_d;
      in_msg_q    <= in_msg_d;
      last_seen_q <= last_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    rate_d      = rate_q;
    in_msg_d    = in_msg_q;
    last_seen_d = last_seen_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_acc && !beat_noop) begin
          acc_d       = acc_q | beat_placed;
          fill_d      = new_fill;
          rate_d      = beat_rate;
          in_msg_d    = 1'b1;
          last_seen_d = in_last_i;
          if (new_fill >= beat_rate_bytes) begin
            state_d = ST_FULL;
          end else if (in_last_i) begin
            state_d = ST_FINAL;
          end
        end
      end
      ST_FULL: begin
        if (out_acc) begin
          acc_d  = acc_q << rate_sh;
          fill_d = fill_q - rate_bytes;
          if (!last_seen_q) begin
            state_d = ST_ACCUM;
`ifdef ASCON_PAD_EN
          end else begin
            state_d = ST_FINAL;
          end
`else
          end else if (fill_q != rate_bytes) begin
            state_d = ST_FINAL;
          end else begin
            // The full block was already the last one; the message ends here.
            state_d     = ST_ACCUM;
            in_msg_d    = 1'b0;
            last_seen_d = 1'b0;
          end
`endif
        end
      end
      ST_FINAL: begin
        if (out_acc) begin
          state_d     = ST_ACCUM;
          acc_d       = '0;
          fill_d      = '0;
          in_msg_d    = 1'b0;
          last_seen_d = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_bytes_o = '0;
    out_last_o  = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready_o = 1'b1;
      ST_FULL: begin
        out_valid_o = 1'b1;
        out_data_o  = block_data;
        out_bytes_o = 5'(rate_bytes);
`ifdef ASCON_PAD_EN
        out_last_o  = 1'b0;
`else
        out_last_o  = last_seen_q && (fill_q == rate_bytes);
`endif
      end
      ST_FINAL: begin
        out_valid_o = 1'b1;
`ifdef ASCON_PAD_EN
        out_data_o  = block_data | pad_vec;
`else
        out_data_o  = block_data;
`endif
        out_bytes_o = 5'(fill_q);
        out_last_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_rate_packer.sv
// tb/tb_ascon_rate_packer.sv - scoreboard bench for ascon_rate_packer
module tb_ascon_rate_packer;
  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         rate_sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [3:0]   in_bytes = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;
  logic         out_last;

`ifdef ASCON_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  always #5 clk = ~clk;

  ascon_rate_packer #(.NB_BITS_DATA(64), .BLOCK_W(128)) dut (
    .clock_i(clk), .resetb_i(resetb), .rate_sel_i(rate_sel),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_bytes_i(in_bytes), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_bytes_o(out_bytes), .out_last_o(out_last)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   bytes;
    logic         last;
  } blk_t;

  blk_t        exp_q[$];
  blk_t        mdl_q[$];
  logic [63:0] pb_d[$];
  logic [3:0]  pb_b[$];
  bit          pb_l[$];
  bit          pb_r[$];
  int          checks = 0;
  int          failures = 0;
  bit          rand_ready = 1'b0;
  bit          stuck = 1'b0;

  task automatic check_eq(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int clampb(input logic [3:0] b);
    return (b > 4'd8) ? 8 : int'(b);
  endfunction

  task automatic plan(input logic [63:0] d, input logic [3:0] b, input bit l, input bit r);
    pb_d.push_back(d); pb_b.push_back(b); pb_l.push_back(l); pb_r.push_back(r);
  endtask

  task automatic clear_plan();
    pb_d.delete(); pb_b.delete(); pb_l.delete(); pb_r.delete();
  endtask

  // Whole-message model: concatenate the valid bytes, cut into rate-sized blocks,
  // then finish with the residual block (padded or not).
  task automatic run_model();
    byte unsigned mb[$];
    logic [63:0]  w;
    int           rate;
    bit           have_rate;
    bit           last_nz;
    bit           full_ends;
    int           nfull;
    int           res;
    blk_t         blk;
    rate = 8;
    have_rate = 1'b0;
    for (int i = 0; i < pb_d.size(); i++) begin
      if (!have_rate && (pb_b[i] != 4'd0 || pb_l[i])) begin
        rate = pb_r[i] ? 16 : 8;
        have_rate = 1'b1;
      end
      w = pb_d[i];
      for (int j = 0; j < clampb(pb_b[i]); j++) mb.push_back(w[63-8*j -: 8]);
    end
    last_nz   = clampb(pb_b[pb_b.size()-1]) > 0;
    nfull     = mb.size() / rate;
    res       = mb.size() % rate;
    full_ends = !PAD && (res == 0) && last_nz;
    for (int k = 0; k < nfull; k++) begin
      blk = '0;
      for (int j = 0; j < rate; j++) blk.data[127-8*j -: 8] = mb[k*rate+j];
      blk.bytes = 5'(rate);
      blk.last  = full_ends && (k == nfull - 1);
      mdl_q.push_back(blk);
    end
    if (!full_ends) begin
      blk = '0;
      for (int j = 0; j < res; j++) blk.data[127-8*j -: 8] = mb[nfull*rate+j];
      if (PAD) blk.data[127-8*res -: 8] = 8'h80;
      blk.bytes = 5'(res);
      blk.last  = 1'b1;
      mdl_q.push_back(blk);
    end
  endtask

  // Pins the model against a hand-computed block and queues it for the DUT.
  task automatic expect_lit(input string name, input blk_t lit);
    blk_t m;
    m = '0;
    if (mdl_q.size() != 0) m = mdl_q.pop_front();
    check_eq({"model_", name}, m, lit);
    exp_q.push_back(lit);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] b, input bit l, input bit r);
    int n;
    n = 0;
    in_data = d; in_bytes = b; in_last = l; rate_sel = r; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check_eq("beat_accept", in_ready, 1'b1);
    if (!in_ready) stuck = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_bytes = 4'($urandom);
    in_last  = 1'($urandom);
    rate_sel = 1'($urandom);
    if (rand_ready) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_plan();
    for (int i = 0; i < pb_d.size(); i++) begin
      if (!stuck) send_beat(pb_d[i], pb_b[i], pb_l[i], pb_r[i]);
    end
    clear_plan();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    check_eq("drain_pending_blocks", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_out_data"}, out_data, '0);
    check_eq({tag, "_out_bytes"}, out_bytes, '0);
    check_eq({tag, "_out_last"}, out_last, 1'b0);
  endtask

  // Output monitor: handshake scoreboard, hold-while-stalled, ready/valid exclusivity.
  initial begin
    blk_t cur, prev, e;
    bit   stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = {out_data, out_bytes, out_last};
      if (!resetb) begin
        stall = 1'b0;
      end else begin
        check_eq("ready_vs_valid", in_ready, !out_valid);
        if (stall) check_eq("hold_while_stalled", cur, prev);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_block", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_eq("block", cur, e);
          end
        end
        stall = out_valid && !out_ready;
        prev  = cur;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nbeats;
    bit rs0;
    logic [3:0] b;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outputs("rst");
    @(posedge clk); #1;
    resetb = 1'b1;

    // Single 5-byte beat, rate 8
    plan(64'h0102030405_000000, 4'd5, 1'b1, 1'b0);
    run_model();
`ifdef ASCON_PAD_EN
    expect_lit("single5", {64'h0102030405800000, 64'h0, 5'd5, 1'b1});
`else
    expect_lit("single5", {64'h0102030405000000, 64'h0, 5'd5, 1'b1});
`endif
    send_plan();
    @(negedge clk);
    check_eq("latency_1cycle", out_valid, 1'b1);
    drain();

    // Two full 8-byte beats, rate 8
    plan(64'h1122334455667788, 4'd8, 1'b0, 1'b0);
    plan(64'h99AABBCCDDEEFF00, 4'd8, 1'b1, 1'b0);
    run_model();
    expect_lit("two8_full1", {64'h1122334455667788, 64'h0, 5'd8, 1'b0});
`ifdef ASCON_PAD_EN
    expect_lit("two8_full2", {64'h99AABBCCDDEEFF00, 64'h0, 5'd8, 1'b0});
    expect_lit("two8_final", {64'h8000000000000000, 64'h0, 5'd0, 1'b1});
`else
    expect_lit("two8_full2", {64'h99AABBCCDDEEFF00, 64'h0, 5'd8, 1'b1});
`endif
    send_plan();
    drain();

    // Rate 16, three 6-byte beats with garbage below the valid bytes, select toggled mid-message
    plan(64'h010203040506_FFFF, 4'd6, 1'b0, 1'b1);
    plan(64'h0708090A0B0C_A5A5, 4'd6, 1'b0, 1'b0);
    plan(64'h0D0E0F101112_5A5A, 4'd6, 1'b1, 1'b0);
    run_model();
    expect_lit("r16_full", {128'h0102030405060708090A0B0C0D0E0F10, 5'd16, 1'b0});
`ifdef ASCON_PAD_EN
    expect_lit("r16_final", {24'h111280, 104'h0, 5'd2, 1'b1});
`else
    expect_lit("r16_final", {16'h1112, 112'h0, 5'd2, 1'b1});
`endif
    send_plan();
    drain();

    // Output stall for 5 cycles during FULL, then a zero-byte last beat
    plan(64'hA1A2A3A4A5A6A7A8, 4'd8, 1'b0, 1'b0);
    plan(64'h0123456789ABCDEF, 4'd0, 1'b1, 1'b0);
    run_model();
    expect_lit("stall_full", {64'hA1A2A3A4A5A6A7A8, 64'h0, 5'd8, 1'b0});
`ifdef ASCON_PAD_EN
    expect_lit("stall_final", {8'h80, 120'h0, 5'd0, 1'b1});
`else
    expect_lit("stall_final", {128'h0, 5'd0, 1'b1});
`endif
    clear_plan();
    out_ready = 1'b0;
    send_beat(64'hA1A2A3A4A5A6A7A8, 4'd8, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_out_valid", out_valid, 1'b1);
      check_eq("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_released", {out_valid, in_ready}, 2'b01);
    send_beat(64'h0123456789ABCDEF, 4'd0, 1'b1, 1'b0);
    drain();

    // Reset mid-message after 3 bytes discards them
    send_beat(64'hAABBCC0000000000, 4'd3, 1'b0, 1'b1);
    @(negedge clk); #2;
    resetb = 1'b0;
    @(negedge clk);
    reset_outputs("midrst");
    @(posedge clk); #1;
    resetb = 1'b1;
    plan(64'hDEAD000000000000, 4'd2, 1'b1, 1'b0);
    run_model();
`ifdef ASCON_PAD_EN
    expect_lit("after_rst", {24'hDEAD80, 104'h0, 5'd2, 1'b1});
`else
    expect_lit("after_rst", {16'hDEAD, 112'h0, 5'd2, 1'b1});
`endif
    send_plan();
    drain();

    // Empty message
    plan(64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1, 1'b0);
    run_model();
`ifdef ASCON_PAD_EN
    expect_lit("empty", {8'h80, 120'h0, 5'd0, 1'b1});
`else
    expect_lit("empty", {128'h0, 5'd0, 1'b1});
`endif
    send_plan();
    drain();

    // Randomized messages with random output back-pressure
    rand_ready = 1'b1;
    for (int m = 0; m < 80 && !stuck; m++) begin
      nbeats = $urandom_range(1, 5);
      rs0 = 1'($urandom);
      for (int i = 0; i < nbeats; i++) begin
        b = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 12));
        if (i == 0 && b == 4'd0 && nbeats > 1) b = 4'd1;
        plan({$urandom, $urandom}, b, i == nbeats - 1, (i == 0) ? rs0 : 1'($urandom));
      end
      run_model();
      while (mdl_q.size() != 0) exp_q.push_back(mdl_q.pop_front());
      send_plan();
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
